// File: rtl/spi_reg_rx.sv
// spi_reg_rx: oversampled SPI slave that deserialises MSB-bit frames into a held register.
// Ports:
//   clk        system clock (XTALCLK), all state on posedge
//   rst_n      asynchronous active-low reset
//   sclk       SPI clock pin, asynchronous
//   cs         SPI chip select pin, active low, asynchronous
//   mosi       SPI data in, asynchronous
//   miso       registered SPI data out (previous register value)
//   reg_out    last committed register value
//   reg_update one-clk pulse in the cycle reg_out takes a new value
//   frame_err  one-clk pulse on a rejected frame
module spi_reg_rx #(
    parameter int             MSB       = 8,
    parameter logic [MSB-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sclk,
    input  logic           cs,
    input  logic           mosi,
    output logic           miso,
    output logic [MSB-1:0] reg_out,
    output logic           reg_update,
    output logic           frame_err
);
    localparam int             CW  = $clog2(MSB + 2);
    localparam logic [CW-1:0]  LEN = CW'(MSB);
    localparam logic [CW-1:0]  SAT = CW'(MSB + 1);

    // [0],[1] synchroniser stages, [2] history for edge detection
    logic [2:0]     sclk_q, sclk_d, cs_q, cs_d;
    logic [1:0]     mosi_q, mosi_d;
    // fill_q marks when the synchronisers hold real pin samples rather than reset values
    logic [1:0]     fill_q, fill_d;
    logic           armed_q, armed_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MSB-1:0] shift_q, shift_d, shadow_q, shadow_d, regv_q, regv_d;
    logic           miso_q, miso_d, upd_q, upd_d, err_q, err_d;
    logic           sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    always_comb begin
        sclk_d   = {sclk_q[1:0], sclk};
        cs_d     = {cs_q[1:0], cs};
        mosi_d   = {mosi_q[0], mosi};
        fill_d   = {fill_q[0], 1'b1};
        // Arm only on a genuine high cs sample so a reset released mid-frame drops that frame
        armed_d  = armed_q | (fill_q[1] & cs_q[1]);
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        miso_d   = cs_q[1] ? 1'b0 : miso_q;
        regv_d   = regv_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        if (armed_q) begin
            if (cs_fall) begin
                cnt_d    = '0;
                shadow_d = regv_q;
                miso_d   = regv_q[MSB-1];
            end else if (cs_rise) begin
                regv_d = (cnt_q == LEN) ? shift_q : regv_q;
                upd_d  = (cnt_q == LEN);
                err_d  = (cnt_q != LEN);
            end else if (!cs_q[1]) begin
                if (sclk_fall) begin
                    shift_d = {shift_q[MSB-2:0], mosi_q[1]};
                    // saturate past MSB so over-long frames never wrap back to a valid count
                    cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
                end
                if (sclk_rise) begin
                    shadow_d = shadow_q << 1;
                    miso_d   = shadow_q[MSB-2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q   <= 3'b000;
            cs_q     <= 3'b111;
            mosi_q   <= 2'b00;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            miso_q   <= 1'b0;
            regv_q   <= RESET_VAL;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            fill_q   <= fill_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            miso_q   <= miso_d;
            regv_q   <= regv_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign miso       = miso_q;
    assign reg_out    = regv_q;
    assign reg_update = upd_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_spi_reg_rx.sv
// tb_spi_reg_rx: directed self-checking bench for spi_reg_rx.
module tb_spi_reg_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b1;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] reg_out;
    logic       reg_update;
    logic       frame_err;
    int         total = 0;
    int         bad = 0;
    int         n_upd = 0;
    int         n_err = 0;
    int         n_both = 0;
    int         u0, e0;
    logic [31:0] rd;

    spi_reg_rx #(.MSB(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .reg_out(reg_out), .reg_update(reg_update), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_update) n_upd++;
        if (frame_err) n_err++;
        if (reg_update && frame_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // CPOL=1 master: data driven while sclk high, slave samples on fall, MISO read just before fall
    task automatic send(input logic [31:0] d, input int n, input bit start, output logic [31:0] r);
        r = '0;
        if (start) begin
            cs = 1'b0;
            tick(8);
        end
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            tick(4);
            r = {r[30:0], miso};
            sclk = 1'b0;
            tick(8);
            sclk = 1'b1;
            tick(8);
        end
    endtask

    task automatic end_frame;
        cs = 1'b1;
        tick(10);
    endtask

    initial begin
        tick(3);
        chk("rst_reg", reg_out, 8'h00);
        chk("rst_miso", miso, 1'b0);
        chk("rst_upd", reg_update, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(6);

        send(32'h01, 8, 1, rd);
        cs = 1'b1;
        tick(2);
        chk("lat_hold", reg_out, 8'h00);
        chk("lat_noupd", reg_update, 1'b0);
        tick(1);
        chk("lat_reg", reg_out, 8'h01);
        chk("lat_upd", reg_update, 1'b1);
        tick(1);
        chk("upd_1cyc", reg_update, 1'b0);
        tick(8);
        chk("w01_cnt", n_upd, 1);
        chk("w01_noerr", n_err, 0);

        send(32'hA5, 8, 1, rd);
        end_frame();
        chk("wa5", reg_out, 8'hA5);
        send(32'h3C, 8, 1, rd);
        end_frame();
        chk("readback", rd, 32'hA5);
        chk("w3c", reg_out, 8'h3C);
        chk("miso_idle", miso, 1'b0);

        u0 = n_upd; e0 = n_err;
        send(32'h7F, 7, 1, rd);
        end_frame();
        chk("len7_reg", reg_out, 8'h3C);
        chk("len7_err", n_err - e0, 1);
        chk("len7_upd", n_upd - u0, 0);
        u0 = n_upd; e0 = n_err;
        send(32'hFF02, 16, 1, rd);
        end_frame();
        chk("len16_reg", reg_out, 8'h3C);
        chk("len16_err", n_err - e0, 1);
        chk("len16_upd", n_upd - u0, 0);

        u0 = n_upd; e0 = n_err;
        cs = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(10);
        chk("glitch_err", n_err - e0, 1);
        chk("glitch_reg", reg_out, 8'h3C);
        e0 = n_err;
        for (int i = 0; i < 6; i++) begin
            mosi = i[0];
            sclk = ~sclk;
            tick(5);
        end
        sclk = 1'b1;
        tick(5);
        chk("idle_err", n_err - e0, 0);
        chk("idle_upd", n_upd - u0, 0);
        chk("idle_reg", reg_out, 8'h3C);
        chk("idle_miso", miso, 1'b0);

        u0 = n_upd; e0 = n_err;
        send(32'h5, 4, 1, rd);
        rst_n = 1'b0;
        #1;
        chk("async_rst", reg_out, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send(32'h5, 4, 0, rd);
        end_frame();
        chk("midrst_err", n_err - e0, 0);
        chk("midrst_upd", n_upd - u0, 0);
        chk("midrst_reg", reg_out, 8'h00);
        send(32'h55, 8, 1, rd);
        end_frame();
        chk("post_rst", reg_out, 8'h55);
        chk("post_upd", n_upd - u0, 1);
        chk("exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_rx.md
Name: spi_reg_rx

Overview:
- Oversampled SPI slave front end running entirely in the XTALCLK domain.
- Synchronises SCLK/CS/MOSI and deserialises exactly-MSB-bit frames into a held register; that register drives the peripheral select mux (e.g. ADC03_SCLK routing).
- Returns the previous register value on MISO for readback.
- Replaces the dual-edge SCLK/CS-clocked latch with a single-clock design carrying frame-length checking and an update strobe.

Parameters:
- MSB, 8, register width in bits; a valid frame carries exactly MSB bits.
- RESET_VAL, 0, value loaded into reg_out on reset (MSB bits wide).

Ports:
- clk  input  1  system clock (XTALCLK); all state on posedge clk
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock pin, asynchronous to clk
- cs  input  1  SPI chip select pin, active low, asynchronous
- mosi  input  1  SPI data in, asynchronous
- miso  output  1  SPI data out (registered)
- reg_out  output  MSB  last committed register value
- reg_update  output  1  one-clk pulse, asserted in the cycle reg_out takes a new value
- frame_err  output  1  one-clk pulse on a rejected frame

Behaviour:
- Reset (rst_n low, async):
  - reg_out=RESET_VAL; miso=0; reg_update=0; frame_err=0.
  - Shift register, bit counter and shadow register = 0; armed=0; synchroniser flops = idle (sclk 0, cs 1).
- Synchronisers:
  - sclk, cs and mosi each pass through a 2-flop synchroniser plus one history flop for edge detection.
  - Edge strobes: sclk_fall, sclk_rise, cs_fall, cs_rise. Each is high for exactly one clk.
- Timing requirement: SCLK high and low phases each ≥ 3 clk periods; CS setup/hold to first/last SCLK edge ≥ 3 clk.
- Arming:
  - armed is set when synchronised cs is seen high; it is cleared only by reset.
  - While armed=0, all SCLK edges and cs_fall are ignored. Leaving reset mid-frame therefore discards the remainder of that frame.
- Frame start (cs_fall, armed):
  - bit counter=0; shadow=reg_out; miso=reg_out[MSB-1] in the following cycle.
- Receive, on sclk_fall while synchronised cs low:
  - shift={shift[MSB-2:0], mosi_sync}.
  - Counter increments, saturating at MSB+1 so that 16/24-bit frames never alias to MSB.
- Transmit, on sclk_rise while cs low:
  - shadow shifts left by one (0 in); miso=new shadow[MSB-1].
  - Master samples MISO on the falling edge.
- Frame end (cs_rise), committing a valid frame:
  - If counter==MSB: reg_out=shift and reg_update=1, both in the same cycle.
  - Latency: reg_out changes on the 3rd posedge clk after the cs pin rises.
- Frame end (cs_rise), rejecting:
  - If counter≠MSB, including 0 edges (CS glitch): frame_err=1 for one clk; reg_out unchanged; reg_update=0.
- After frame end: miso=0 while cs high.
- Simultaneous events, same cycle:
  - cs_rise with sclk_fall: the edge is ignored; commit uses the prior count.
  - cs_fall with any sclk edge: the edge is ignored.
- Idle and non-frame edges:
  - SCLK edges while cs high: no state change.
  - reg_out holds indefinitely between valid frames.
- reg_update and frame_err are mutually exclusive and never asserted for longer than one cycle.

Test Plan:
- Reset: assert rst_n=0 mid-simulation → reg_out=RESET_VAL, miso=0, no pulses; release with cs high → next frame accepted.
- Valid write: send 8'h01 MSB-first (8 falling edges) → on 3rd clk after cs rises, reg_out=8'h01 with a single reg_update pulse; frame_err stays 0.
- Readback: after reg_out=8'hA5, send 8'h3C → MISO bits sampled on SCLK falls = 1,0,1,0,0,1,0,1; then reg_out=8'h3C.
- Wrong length: send 7 bits, then 16 bits (8'hFF,8'h02) → frame_err pulse each time; reg_out stays at previous value; no reg_update.
- CS glitch: cs low for 2 clk with no SCLK edges → one frame_err; SCLK toggling while cs high → no state change.
- Reset mid-frame: pulse rst_n low after 4 bits with cs still low, then 4 more bits and cs high → no commit and no frame_err (not armed); next full 8-bit frame 8'h55 → reg_out=8'h55.
